// File: rtl/btb_pkg.sv
// Shared types and helpers for the 2-way set-associative branch target cache.
// Entry fields use fixed maximum widths; narrower configurations leave upper bits zero.
package btb_pkg;

    localparam int TAG_W_MAX = 30;
    localparam int CTR_W_MAX = 8;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [31:0]          target;
        logic [CTR_W_MAX-1:0] ctr;
    } btb_entry_t;

    function automatic logic [CTR_W_MAX-1:0] ctr_max(input int ctr_bits);
        return CTR_W_MAX'((9'd1 << ctr_bits) - 9'd1);
    endfunction

    function automatic logic [CTR_W_MAX-1:0] weak_taken(input int ctr_bits);
        return CTR_W_MAX'(9'd1 << (ctr_bits - 1));
    endfunction

    function automatic logic [CTR_W_MAX-1:0] sat_inc(input logic [CTR_W_MAX-1:0] ctr,
                                                     input int ctr_bits);
        return (ctr >= ctr_max(ctr_bits)) ? ctr : ctr + 8'd1;
    endfunction

    function automatic logic [CTR_W_MAX-1:0] sat_dec(input logic [CTR_W_MAX-1:0] ctr);
        return (ctr == '0) ? ctr : ctr - 8'd1;
    endfunction

    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int set_bits);
        return (pc >> 2) & ((32'd1 << set_bits) - 32'd1);
    endfunction

    // Tag is the top tag_bits of the PC, zero-extended to the storage width.
    function automatic logic [TAG_W_MAX-1:0] pc_tag(input logic [31:0] pc, input int tag_bits);
        return TAG_W_MAX'(pc >> (32 - tag_bits));
    endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the branch target cache: per-set storage with a lookup read port,
// an update read port and a single write port sharing the update index.
module btb_way
    import btb_pkg::*;
#(
    parameter int SET_BITS = 5,
    parameter int CTR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 clr_i,
    input  logic [SET_BITS-1:0]  lkp_idx_i,
    output logic                 lkp_valid_o,
    output logic [TAG_W_MAX-1:0] lkp_tag_o,
    output logic [31:0]          lkp_target_o,
    output logic                 lkp_taken_o,
    input  logic [SET_BITS-1:0]  upd_idx_i,
    output logic                 upd_valid_o,
    output logic [TAG_W_MAX-1:0] upd_tag_o,
    output logic [CTR_W_MAX-1:0] upd_ctr_o,
    input  logic                 we_i,
    input  btb_entry_t           wr_i
);

    localparam int SETS = 1 << SET_BITS;

    logic                 valid_q  [SETS];
    logic [CTR_W_MAX-1:0] ctr_q    [SETS];
    logic [TAG_W_MAX-1:0] tag_q    [SETS];
    logic [31:0]          target_q [SETS];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= '0;
            end
        end else if (we_i) begin
            valid_q[upd_idx_i] <= wr_i.valid;
            ctr_q[upd_idx_i]   <= wr_i.ctr;
        end
    end

    // Tag and target are meaningless while invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[upd_idx_i]    <= wr_i.tag;
            target_q[upd_idx_i] <= wr_i.target;
        end
    end

    assign lkp_valid_o  = valid_q[lkp_idx_i];
    assign lkp_tag_o    = tag_q[lkp_idx_i];
    assign lkp_target_o = target_q[lkp_idx_i];
    assign lkp_taken_o  = ctr_q[lkp_idx_i][CTR_BITS-1];

    assign upd_valid_o  = valid_q[upd_idx_i];
    assign upd_tag_o    = tag_q[upd_idx_i];
    assign upd_ctr_o    = ctr_q[upd_idx_i];

endmodule

// File: rtl/branch_target_cache.sv
// 2-way set-associative branch target cache: zero-latency fetch lookup,
// decode-stage update with LRU replacement and allocate-on-taken.
module branch_target_cache
    import btb_pkg::*;
#(
    parameter int SET_BITS = 5,
    parameter int CTR_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instructionPC,
    output logic [31:0] predictedPC,
    output logic        prediction,
    output logic        hit,
    input  logic        flush,
    input  logic        isBranch,
    input  logic [31:0] PCD,
    input  logic [31:0] branchTargetD,
    input  logic        branchTaken,
    input  logic        branchstall
);

    localparam int SETS     = 1 << SET_BITS;
    localparam int TAG_BITS = 30 - SET_BITS;
    localparam logic [CTR_W_MAX-1:0] WEAK_TAKEN = weak_taken(CTR_BITS);

    logic                 clr;
    logic [SET_BITS-1:0]  lkp_idx, upd_idx;
    logic [TAG_W_MAX-1:0] lkp_tag, upd_tag;

    logic [1:0]           lkp_valid, lkp_taken, lkp_hit;
    logic [TAG_W_MAX-1:0] lkp_tag_w [2];
    logic [31:0]          lkp_target [2];
    logic [1:0]           upd_valid, upd_hit;
    logic [TAG_W_MAX-1:0] upd_tag_w [2];
    logic [CTR_W_MAX-1:0] upd_ctr [2];

    logic                 upd_en, do_write, upd_way, lru_d;
    logic [CTR_W_MAX-1:0] old_ctr;
    logic [1:0]           way_we;
    btb_entry_t           wr_entry;
    logic                 lru_q [SETS];

    assign clr     = reset | flush;
    assign lkp_idx = SET_BITS'(pc_index(instructionPC, SET_BITS));
    assign upd_idx = SET_BITS'(pc_index(PCD, SET_BITS));
    assign lkp_tag = pc_tag(instructionPC, TAG_BITS);
    assign upd_tag = pc_tag(PCD, TAG_BITS);

    for (genvar w = 0; w < 2; w++) begin : g_way
        btb_way #(.SET_BITS(SET_BITS), .CTR_BITS(CTR_BITS)) u_way (
            .clk         (clk),
            .clr_i       (clr),
            .lkp_idx_i   (lkp_idx),
            .lkp_valid_o (lkp_valid[w]),
            .lkp_tag_o   (lkp_tag_w[w]),
            .lkp_target_o(lkp_target[w]),
            .lkp_taken_o (lkp_taken[w]),
            .upd_idx_i   (upd_idx),
            .upd_valid_o (upd_valid[w]),
            .upd_tag_o   (upd_tag_w[w]),
            .upd_ctr_o   (upd_ctr[w]),
            .we_i        (way_we[w]),
            .wr_i        (wr_entry)
        );
        assign lkp_hit[w] = lkp_valid[w] && (lkp_tag_w[w] == lkp_tag);
        assign upd_hit[w] = upd_valid[w] && (upd_tag_w[w] == upd_tag);
    end

    // At most one way matches, so a simple priority select is exact.
    assign hit         = |lkp_hit;
    assign prediction  = lkp_hit[1] ? lkp_taken[1] : (lkp_hit[0] & lkp_taken[0]);
    assign predictedPC = lkp_hit[1] ? lkp_target[1] :
                         lkp_hit[0] ? lkp_target[0] : instructionPC + 32'd4;

    always_comb begin
        upd_en  = isBranch && !branchstall && !reset && !flush;
        upd_way = upd_hit[1];
        if (upd_hit == 2'b00) begin
            upd_way = !upd_valid[0] ? 1'b0 : (!upd_valid[1] ? 1'b1 : lru_q[upd_idx]);
        end
        old_ctr         = upd_hit[1] ? upd_ctr[1] : upd_ctr[0];
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = upd_tag;
        wr_entry.target = branchTargetD;
        if (|upd_hit) begin
            wr_entry.ctr = branchTaken ? sat_inc(old_ctr, CTR_BITS) : sat_dec(old_ctr);
        end else begin
            wr_entry.ctr = WEAK_TAKEN;
        end
        do_write = upd_en && ((|upd_hit) || branchTaken);
        way_we   = 2'b00;
        if (do_write) begin
            way_we[upd_way] = 1'b1;
        end
        lru_d = !upd_way;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < SETS; i++) begin
                lru_q[i] <= 1'b0;
            end
        end else if (do_write) begin
            lru_q[upd_idx] <= lru_d;
        end
    end

endmodule

// File: tb/tb_branch_target_cache.sv
// Self-checking bench for branch_target_cache: directed scenarios plus a
// randomized run compared against a behavioural model of the cache.
module tb_branch_target_cache;

    logic        clk;
    logic        reset;
    logic [31:0] instructionPC;
    logic [31:0] predictedPC;
    logic        prediction;
    logic        hit;
    logic        flush;
    logic        isBranch;
    logic [31:0] PCD;
    logic [31:0] branchTargetD;
    logic        branchTaken;
    logic        branchstall;

    int passed = 0;
    int total  = 0;

    branch_target_cache #(.SET_BITS(5), .CTR_BITS(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .instructionPC(instructionPC),
        .predictedPC  (predictedPC),
        .prediction   (prediction),
        .hit          (hit),
        .flush        (flush),
        .isBranch     (isBranch),
        .PCD          (PCD),
        .branchTargetD(branchTargetD),
        .branchTaken  (branchTaken),
        .branchstall  (branchstall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: 32 sets x 2 ways, counters as plain integers in 0..3.
    bit          m_valid [32][2];
    int unsigned m_tag   [32][2];
    logic [31:0] m_tgt   [32][2];
    int          m_ctr   [32][2];
    int          m_lru   [32];

    function automatic void model_clear();
        for (int s = 0; s < 32; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 0;
                m_ctr[s][w]   = 0;
            end
        end
    endfunction

    function automatic int model_find(input logic [31:0] pc);
        int s = int'((pc >> 2) % 32);
        int unsigned t = pc >> 7;
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic [31:0] tgt, input bit tkn);
        int s = int'((pc >> 2) % 32);
        int w = model_find(pc);
        if (w >= 0) begin
            m_tgt[s][w] = tgt;
            m_ctr[s][w] = tkn ? ((m_ctr[s][w] == 3) ? 3 : m_ctr[s][w] + 1)
                              : ((m_ctr[s][w] == 0) ? 0 : m_ctr[s][w] - 1);
            m_lru[s] = 1 - w;
        end else if (tkn) begin
            w = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : m_lru[s]);
            m_valid[s][w] = 1;
            m_tag[s][w]   = pc >> 7;
            m_tgt[s][w]   = tgt;
            m_ctr[s][w]   = 2;
            m_lru[s]      = 1 - w;
        end
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output bit h, output bit p,
                                         output logic [31:0] ppc);
        int s = int'((pc >> 2) % 32);
        int w = model_find(pc);
        h = (w >= 0);
        p = h && (m_ctr[s][w] >= 2);
        ppc = h ? m_tgt[s][w] : pc + 32'd4;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset || flush) model_clear();
        else if (isBranch && !branchstall) model_update(PCD, branchTargetD, branchTaken);
        #1;
        reset = 0; flush = 0; isBranch = 0; branchstall = 0; branchTaken = 0;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tkn, input bit stall);
        isBranch = 1; PCD = pc; branchTargetD = tgt; branchTaken = tkn; branchstall = stall;
    endtask

    task automatic look(input logic [31:0] pc);
        instructionPC = pc;
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        look(32'h100);
        total++; if (hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", hit); else passed++;
        total++; if (prediction !== 1'b0) $display("FAIL reset_pred: got %b want 0", prediction); else passed++;
        total++; if (predictedPC !== 32'h104) $display("FAIL reset_ppc: got %h want 00000104", predictedPC); else passed++;
    endtask

    task automatic test_basic();
        drive_upd(32'h100, 32'h200, 1, 0); tick();
        look(32'h100);
        total++; if (hit !== 1'b1) $display("FAIL alloc_hit: got %b want 1", hit); else passed++;
        total++; if (prediction !== 1'b1) $display("FAIL alloc_pred: got %b want 1", prediction); else passed++;
        total++; if (predictedPC !== 32'h200) $display("FAIL alloc_ppc: got %h want 00000200", predictedPC); else passed++;
        drive_upd(32'h100, 32'h200, 0, 0);
        look(32'h100);
        total++; if (prediction !== 1'b1) $display("FAIL same_cycle_pred: got %b want 1", prediction); else passed++;
        tick();
        look(32'h100);
        total++; if (hit !== 1'b1) $display("FAIL nt_hit: got %b want 1", hit); else passed++;
        total++; if (prediction !== 1'b0) $display("FAIL nt_pred: got %b want 0", prediction); else passed++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin drive_upd(32'h100, 32'h200, 1, 0); tick(); end
        look(32'h100);
        total++; if (prediction !== 1'b1) $display("FAIL sat_hi_pred: got %b want 1", prediction); else passed++;
        drive_upd(32'h100, 32'h200, 0, 0); tick(); look(32'h100);
        total++; if (prediction !== 1'b1) $display("FAIL sat_hi_nowrap: got %b want 1", prediction); else passed++;
        for (int i = 0; i < 4; i++) begin drive_upd(32'h100, 32'h200, 0, 0); tick(); end
        look(32'h100);
        total++; if (hit !== 1'b1) $display("FAIL sat_lo_hit: got %b want 1", hit); else passed++;
        total++; if (prediction !== 1'b0) $display("FAIL sat_lo_pred: got %b want 0", prediction); else passed++;
        drive_upd(32'h100, 32'h200, 1, 0); tick(); look(32'h100);
        total++; if (prediction !== 1'b0) $display("FAIL sat_lo_nowrap: got %b want 0", prediction); else passed++;
        drive_upd(32'h100, 32'h200, 1, 0); tick(); look(32'h100);
        total++; if (prediction !== 1'b1) $display("FAIL sat_recover: got %b want 1", prediction); else passed++;
    endtask

    task automatic test_replacement();
        reset = 1; tick();
        drive_upd(32'h100, 32'h1100, 1, 0); tick();
        drive_upd(32'h180, 32'h1180, 1, 0); tick();
        drive_upd(32'h180, 32'h1180, 1, 0); tick();
        drive_upd(32'h200, 32'h1200, 1, 0); tick();
        look(32'h100);
        total++; if (hit !== 1'b0) $display("FAIL evict_old_hit: got %b want 0", hit); else passed++;
        total++; if (predictedPC !== 32'h104) $display("FAIL evict_old_ppc: got %h want 00000104", predictedPC); else passed++;
        look(32'h180);
        total++; if (hit !== 1'b1) $display("FAIL keep_mru_hit: got %b want 1", hit); else passed++;
        total++; if (predictedPC !== 32'h1180) $display("FAIL keep_mru_ppc: got %h want 00001180", predictedPC); else passed++;
        look(32'h200);
        total++; if (hit !== 1'b1) $display("FAIL new_hit: got %b want 1", hit); else passed++;
        total++; if (predictedPC !== 32'h1200) $display("FAIL new_ppc: got %h want 00001200", predictedPC); else passed++;
    endtask

    task automatic test_gating();
        drive_upd(32'h40, 32'h900, 1, 1); tick();
        look(32'h40);
        total++; if (hit !== 1'b0) $display("FAIL stall_alloc_hit: got %b want 0", hit); else passed++;
        drive_upd(32'h44, 32'h900, 0, 0); tick();
        look(32'h44);
        total++; if (hit !== 1'b0) $display("FAIL nt_alloc_hit: got %b want 0", hit); else passed++;
        look(32'h40);
        total++; if (hit !== 1'b0) $display("FAIL stall_alloc_hit2: got %b want 0", hit); else passed++;
        for (int i = 0; i < 2; i++) begin drive_upd(32'h180, 32'hDEAD0, 0, 1); tick(); end
        look(32'h180);
        total++; if (prediction !== 1'b1) $display("FAIL stall_ctr_pred: got %b want 1", prediction); else passed++;
        total++; if (predictedPC !== 32'h1180) $display("FAIL stall_tgt_ppc: got %h want 00001180", predictedPC); else passed++;
    endtask

    task automatic test_flush();
        drive_upd(32'h300, 32'h1300, 1, 0); flush = 1; tick();
        look(32'h300);
        total++; if (hit !== 1'b0) $display("FAIL flush_upd_hit: got %b want 0", hit); else passed++;
        look(32'h180);
        total++; if (hit !== 1'b0) $display("FAIL flush_old_hit: got %b want 0", hit); else passed++;
        look(32'h200);
        total++; if (hit !== 1'b0) $display("FAIL flush_old_hit2: got %b want 0", hit); else passed++;
        look(32'hFFFF_FFFC);
        total++; if (predictedPC !== 32'h0) $display("FAIL wrap_ppc: got %h want 00000000", predictedPC); else passed++;
        drive_upd(32'h300, 32'h1300, 1, 0); tick(); look(32'h300);
        total++; if (hit !== 1'b1) $display("FAIL post_flush_alloc: got %b want 1", hit); else passed++;
        drive_upd(32'h500, 32'h1500, 1, 0); reset = 1; tick(); look(32'h500);
        total++; if (hit !== 1'b0) $display("FAIL reset_upd_hit: got %b want 0", hit); else passed++;
        look(32'h300);
        total++; if (hit !== 1'b0) $display("FAIL reset_old_hit: got %b want 0", hit); else passed++;
    endtask

    task automatic test_random();
        bit          eh, ep;
        logic [31:0] eppc, pc;
        reset = 1; tick();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                drive_upd((32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 3)) << 2),
                          $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 9) == 0);
            end
            flush = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 99) == 0);
            pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
               : (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 3)) << 2);
            look(pc);
            model_lookup(pc, eh, ep, eppc);
            total++; if (hit !== eh) $display("FAIL rnd_hit[%0d] pc=%h: got %b want %b", n, pc, hit, eh); else passed++;
            total++; if (prediction !== ep) $display("FAIL rnd_pred[%0d] pc=%h: got %b want %b", n, pc, prediction, ep); else passed++;
            total++; if (predictedPC !== eppc) $display("FAIL rnd_ppc[%0d] pc=%h: got %h want %h", n, pc, predictedPC, eppc); else passed++;
            tick();
        end
    endtask

    initial begin
        reset = 1; flush = 0; isBranch = 0; PCD = '0; branchTargetD = '0;
        branchTaken = 0; branchstall = 0; instructionPC = '0;
        model_clear();
        test_reset();
        test_basic();
        test_saturation();
        test_replacement();
        test_gating();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
